// File: rtl/rv32_fetch.sv
// ---------------------------------------------------------------------------
// rv32_fetch
//
// Instruction fetch stage of the rv32 pipeline. Owns the PC, runs the
// instruction-bus read handshake, applies a static branch predictor and
// presents one registered instruction slot per cycle to decode.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ce_i                       clock enable; all state holds when low
//   stall_in / flush_in        hazard unit: hold outputs+PC / bubble next slot
//   branch_mispredicted_in,
//   branch_pc_in               execute redirect
//   trap_in, trap_pc_in        writeback redirect (wins over mispredict)
//   instr_read_out,
//   instr_address_out          bus request and word address
//   instr_ready_in,
//   instr_fault_in,
//   instr_read_value_in        bus response (fault/data qualified by ready)
//   valid_out, exception_out,
//   exception_cause_out,
//   branch_predicted_taken_out,
//   pc_out, instr_out          registered decode-facing slot
// ---------------------------------------------------------------------------
module rv32_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter bit          PREDICT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_i,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        branch_mispredicted_in,
  input  logic [31:0] branch_pc_in,
  input  logic        trap_in,
  input  logic [31:0] trap_pc_in,
  output logic        instr_read_out,
  output logic [31:0] instr_address_out,
  input  logic        instr_ready_in,
  input  logic        instr_fault_in,
  input  logic [31:0] instr_read_value_in,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  exception_cause_out,
  output logic        branch_predicted_taken_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  typedef enum logic [1:0] {
    S_FETCH, // issue or await a request
    S_HOLD,  // response buffered while decode is stalled
    S_DRAIN, // swallow the response of a request made before a redirect
    S_HALT   // stopped after a fetch exception, waiting for a redirect
  } state_t;

  localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_FAULT      = 4'd1;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] drain_addr_q;
  logic [31:0] hold_word_q;
  logic        hold_fault_q;

  logic        valid_q;
  logic        exc_q;
  logic [3:0]  cause_q;
  logic        pred_q;
  logic [31:0] pc_out_q;
  logic [31:0] instr_q;

  // ------------------------------------------------------------------------
  // Redirect and bus request
  // ------------------------------------------------------------------------
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misaligned;
  logic        bus_req;

  assign redirect    = trap_in | branch_mispredicted_in;
  assign redirect_pc = trap_in ? trap_pc_in : branch_pc_in;
  assign misaligned  = (pc_q[1:0] != 2'b00);

  // A misaligned PC never reaches the bus. While draining, the old address
  // stays on the bus so the request is not withdrawn before ready.
  assign bus_req = ((state_q == S_FETCH) && !misaligned) || (state_q == S_DRAIN);

  // The request is gated by reset so every output reads 0 while in reset.
  assign instr_read_out    = bus_req & ~reset;
  assign instr_address_out = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

  // ------------------------------------------------------------------------
  // Candidate instruction: fresh from the bus in FETCH, buffered in HOLD
  // ------------------------------------------------------------------------
  logic        avail;
  logic [31:0] avail_word;
  logic        avail_fault;

  assign avail       = ((state_q == S_FETCH) && !misaligned && instr_ready_in) ||
                       (state_q == S_HOLD);
  assign avail_word  = (state_q == S_HOLD) ? hold_word_q  : instr_read_value_in;
  assign avail_fault = (state_q == S_HOLD) ? hold_fault_q : instr_fault_in;

  // ------------------------------------------------------------------------
  // Static predictor: JAL and backward conditional branches are taken
  // ------------------------------------------------------------------------
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic        is_jal;
  logic        is_back_branch;
  logic        pred_taken;
  logic [31:0] pred_next_pc;

  assign j_imm = {{12{avail_word[31]}}, avail_word[19:12], avail_word[20],
                  avail_word[30:21], 1'b0};
  assign b_imm = {{20{avail_word[31]}}, avail_word[7], avail_word[30:25],
                  avail_word[11:8], 1'b0};

  assign is_jal         = (avail_word[6:0] == OP_JAL);
  assign is_back_branch = (avail_word[6:0] == OP_BRANCH) && avail_word[31];
  assign pred_taken     = PREDICT_EN && (is_jal || is_back_branch);
  assign pred_next_pc   = pred_taken ? pc_q + (is_jal ? j_imm : b_imm)
                                     : pc_q + 32'd4;

  // ------------------------------------------------------------------------
  // Slot that would be presented to decode this cycle if not stalled
  // ------------------------------------------------------------------------
  logic        slot_valid;
  logic        slot_exc;
  logic [3:0]  slot_cause;
  logic        slot_pred;
  logic [31:0] slot_instr;

  // NOTE: every signal written here gets a default first so no latch is
  // inferred on paths that leave it untouched.
  always_comb begin
    slot_valid = 1'b0;
    slot_exc   = 1'b0;
    slot_cause = CAUSE_MISALIGNED;
    slot_pred  = 1'b0;
    slot_instr = '0;
    if ((state_q == S_FETCH) && misaligned) begin
      slot_exc   = 1'b1;
      slot_cause = CAUSE_MISALIGNED;
    end else if (avail) begin
      if (avail_fault) begin
        slot_exc   = 1'b1;
        slot_cause = CAUSE_FAULT;
      end else begin
        slot_valid = 1'b1;
        slot_instr = avail_word;
        slot_pred  = pred_taken;
      end
    end
  end

  // ------------------------------------------------------------------------
  // State, PC and registered decode slot
  // ------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_VECTOR;
      drain_addr_q <= '0;
      hold_word_q  <= '0;
      hold_fault_q <= 1'b0;
      valid_q      <= 1'b0;
      exc_q        <= 1'b0;
      cause_q      <= '0;
      pred_q       <= 1'b0;
      pc_out_q     <= '0;
      instr_q      <= '0;
    end else if (ce_i) begin
      // Decode-facing slot: redirect/flush force a bubble, stall freezes it,
      // otherwise whatever was produced this cycle (possibly nothing).
      if (redirect || flush_in) begin
        valid_q <= 1'b0;
        exc_q   <= 1'b0;
        cause_q <= '0;
        pred_q  <= 1'b0;
      end else if (!stall_in) begin
        valid_q  <= slot_valid;
        exc_q    <= slot_exc;
        cause_q  <= slot_cause;
        pred_q   <= slot_pred;
        pc_out_q <= pc_q;
        instr_q  <= slot_instr;
      end

      if (redirect) begin
        pc_q         <= redirect_pc;
        hold_word_q  <= '0;
        hold_fault_q <= 1'b0;
        // A request still in flight must complete before the new PC is
        // fetched; a further redirect while draining keeps the old address.
        if (bus_req && !instr_ready_in) begin
          state_q      <= S_DRAIN;
          drain_addr_q <= instr_address_out;
        end else begin
          state_q <= S_FETCH;
        end
      end else begin
        unique case (state_q)
          S_FETCH: begin
            if (misaligned) begin
              if (!stall_in) state_q <= S_HALT;
            end else if (instr_ready_in) begin
              if (stall_in) begin
                hold_word_q  <= instr_read_value_in;
                hold_fault_q <= instr_fault_in;
                state_q      <= S_HOLD;
              end else if (instr_fault_in) begin
                state_q <= S_HALT;
              end else begin
                pc_q <= pred_next_pc;
              end
            end
          end
          S_HOLD: begin
            if (!stall_in) begin
              if (hold_fault_q) begin
                state_q <= S_HALT;
              end else begin
                pc_q    <= pred_next_pc;
                state_q <= S_FETCH;
              end
            end
          end
          S_DRAIN: begin
            if (instr_ready_in) state_q <= S_FETCH;
          end
          S_HALT: begin
            state_q <= S_HALT;
          end
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

  assign valid_out                  = valid_q;
  assign exception_out              = exc_q;
  assign exception_cause_out        = cause_q;
  assign branch_predicted_taken_out = pred_q;
  assign pc_out                     = pc_out_q;
  assign instr_out                  = instr_q;

endmodule

// File: tb/tb_rv32_fetch.sv
// ---------------------------------------------------------------------------
// tb_rv32_fetch
//
// Self-checking bench for rv32_fetch. A directed prologue walks the main
// scenarios (reset, zero-wait fetch, predicted branch, stall, redirect while
// a request is in flight, access fault, misaligned trap target), then a long
// randomized run compares every cycle against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_rv32_fetch;

  localparam logic [31:0] RV = 32'h0000_0100;
  localparam logic [31:0] ADDI = 32'h0010_0093;   // addi x1, x0, 1
  localparam logic [31:0] BEQ_M4 = 32'hFE00_0EE3; // beq x0, x0, -4

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_i;
  logic        stall_in;
  logic        flush_in;
  logic        branch_mispredicted_in;
  logic [31:0] branch_pc_in;
  logic        trap_in;
  logic [31:0] trap_pc_in;
  logic        instr_read_out;
  logic [31:0] instr_address_out;
  logic        instr_ready_in;
  logic        instr_fault_in;
  logic [31:0] instr_read_value_in;
  logic        valid_out;
  logic        exception_out;
  logic [3:0]  exception_cause_out;
  logic        branch_predicted_taken_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  always #5 clk = ~clk;

  rv32_fetch #(.RESET_VECTOR(RV), .PREDICT_EN(1'b1)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .ce_i                       (ce_i),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .branch_mispredicted_in     (branch_mispredicted_in),
    .branch_pc_in               (branch_pc_in),
    .trap_in                    (trap_in),
    .trap_pc_in                 (trap_pc_in),
    .instr_read_out             (instr_read_out),
    .instr_address_out          (instr_address_out),
    .instr_ready_in             (instr_ready_in),
    .instr_fault_in             (instr_fault_in),
    .instr_read_value_in        (instr_read_value_in),
    .valid_out                  (valid_out),
    .exception_out              (exception_out),
    .exception_cause_out        (exception_cause_out),
    .branch_predicted_taken_out (branch_predicted_taken_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model
  // ------------------------------------------------------------------------
  typedef struct packed {
    logic        valid;
    logic        exc;
    logic        pred;
    logic [3:0]  cause;
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;

  logic [31:0] m_pc;          // next instruction to fetch
  bit          m_drain;       // an abandoned request is still on the bus
  logic [31:0] m_drain_addr;
  bit          m_halt;        // stopped after an exception
  bit          m_held;        // response parked during a stall
  logic [31:0] m_hword;
  bit          m_hfault;
  slot_t       m_slot;        // what decode should be seeing

  // Instruction memory: a few fixed words, otherwise a hash of the address
  // biased towards control-flow opcodes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h100 || a == 32'h104 || a == 32'h108 || a == 32'h1FC) return ADDI;
    if (a == 32'h200) return BEQ_M4;
    h = (a >> 2) * 32'h9E37_79B1;
    h = h ^ (h >> 15) ^ 32'h5BD1_E995;
    case (h[3:0])
      4'd0, 4'd1:       return {h[31:7], 7'b1101111};  // jal
      4'd2, 4'd3, 4'd4: return {h[31:7], 7'b1100011};  // branch
      4'd5:             return {h[31:7], 7'b1100111};  // jalr
      default:          return {h[31:7], 7'b0010011};  // alu imm
    endcase
  endfunction

  // Predicted successor, immediates assembled by weighted field sums.
  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] w,
                                          output bit taken);
    logic [31:0] imm;
    taken = 1'b0;
    imm   = 32'd4;
    if (w[6:0] == 7'b1101111) begin
      taken = 1'b1;
      imm = (w[31] ? 32'd0 - 32'd1048576 : 32'd0) + 32'(w[19:12]) * 32'd4096
          + 32'(w[20]) * 32'd2048 + 32'(w[30:21]) * 32'd2;
    end else if (w[6:0] == 7'b1100011 && w[31]) begin
      taken = 1'b1;
      imm = 32'd0 - 32'd4096 + 32'(w[7]) * 32'd2048
          + 32'(w[30:25]) * 32'd32 + 32'(w[11:8]) * 32'd2;
    end
    return pc + imm;
  endfunction

  function automatic bit model_req();
    return !m_halt && !m_held && (m_drain || m_pc[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_addr();
    return m_drain ? m_drain_addr : m_pc;
  endfunction

  task automatic deliver(input logic [31:0] pc, input logic [31:0] w, input bit flt,
                         output slot_t s);
    bit tk;
    s = '0;
    s.pc = pc;
    if (flt) begin
      s.exc   = 1'b1;
      s.cause = 4'd1;
      m_halt  = 1'b1;
    end else begin
      s.valid = 1'b1;
      s.instr = w;
      m_pc    = predict(pc, w, tk);
      s.pred  = tk;
    end
  endtask

  task automatic model_tick(input bit ce, input bit stall, input bit flush, input bit mis,
                            input logic [31:0] bpc, input bit trap, input logic [31:0] tpc,
                            input bit rdy, input bit flt, input logic [31:0] data);
    slot_t       fresh;
    bit          have;
    bit          req;
    logic [31:0] cur_pc;
    if (!ce) return;
    fresh  = '0;
    have   = 1'b0;
    req    = model_req();
    cur_pc = m_pc;
    if (trap || mis) begin
      if (req && !rdy) begin
        if (!m_drain) m_drain_addr = m_pc;
        m_drain = 1'b1;
      end else begin
        m_drain = 1'b0;
      end
      m_pc   = trap ? tpc : bpc;
      m_halt = 1'b0;
      m_held = 1'b0;
      m_slot = '0;
      return;
    end
    if (m_halt) begin
      // nothing until a redirect
    end else if (m_drain) begin
      if (rdy) m_drain = 1'b0;
    end else if (m_held) begin
      if (!stall) begin
        have = 1'b1;
        deliver(cur_pc, m_hword, m_hfault, fresh);
        m_held = 1'b0;
      end
    end else if (cur_pc[1:0] != 2'b00) begin
      if (!stall) begin
        have        = 1'b1;
        fresh.exc   = 1'b1;
        fresh.cause = 4'd0;
        fresh.pc    = cur_pc;
        m_halt      = 1'b1;
      end
    end else if (rdy) begin
      if (stall) begin
        m_held   = 1'b1;
        m_hword  = data;
        m_hfault = flt;
      end else begin
        have = 1'b1;
        deliver(cur_pc, data, flt, fresh);
      end
    end
    if (flush)       m_slot = '0;
    else if (!stall) m_slot = have ? fresh : '0;
  endtask

  task automatic compare();
    bit req;
    req = model_req();
    check("read", {31'd0, instr_read_out}, {31'd0, req});
    if (req) check("addr", instr_address_out, model_addr());
    check("valid", {31'd0, valid_out}, {31'd0, m_slot.valid});
    check("exc", {31'd0, exception_out}, {31'd0, m_slot.exc});
    check("pred", {31'd0, branch_predicted_taken_out}, {31'd0, m_slot.pred});
    if (m_slot.valid || m_slot.exc) check("pc_out", pc_out, m_slot.pc);
    if (m_slot.valid) check("instr", instr_out, m_slot.instr);
    if (m_slot.exc) check("cause", {28'd0, exception_cause_out}, {28'd0, m_slot.cause});
  endtask

  // Called at a negedge: drive one cycle, advance the model, sample at the
  // following negedge.
  task automatic step(input bit ce, input bit stall, input bit flush, input bit mis,
                      input logic [31:0] bpc, input bit trap, input logic [31:0] tpc,
                      input bit rdy, input bit flt);
    logic [31:0] data;
    data = mem_word(model_addr());
    ce_i                   = ce;
    stall_in               = stall;
    flush_in               = flush;
    branch_mispredicted_in = mis;
    branch_pc_in           = bpc;
    trap_in                = trap;
    trap_pc_in             = tpc;
    instr_ready_in         = rdy;
    instr_fault_in         = flt;
    instr_read_value_in    = data;
    model_tick(ce, stall, flush, mis, bpc, trap, tpc, rdy, flt, data);
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    reset                  = 1'b1;
    ce_i                   = 1'b1;
    stall_in               = 1'b0;
    flush_in               = 1'b0;
    branch_mispredicted_in = 1'b0;
    branch_pc_in           = '0;
    trap_in                = 1'b0;
    trap_pc_in             = '0;
    instr_ready_in         = 1'b0;
    instr_fault_in         = 1'b0;
    instr_read_value_in    = '0;

    m_pc = RV; m_drain = 1'b0; m_drain_addr = '0; m_halt = 1'b0;
    m_held = 1'b0; m_hword = '0; m_hfault = 1'b0; m_slot = '0;

    // Reset: every output low.
    repeat (2) @(negedge clk);
    check("rst_read", {31'd0, instr_read_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_exc", {31'd0, exception_out}, 32'd0);
    check("rst_pred", {31'd0, branch_predicted_taken_out}, 32'd0);
    check("rst_cause", {28'd0, exception_cause_out}, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_instr", instr_out, 32'd0);
    reset = 1'b0;
    #1;
    check("first_read", {31'd0, instr_read_out}, 32'd1);
    check("first_addr", instr_address_out, 32'h100);

    // Zero-wait bus, straight-line code.
    idle(1'b1);
    check("d_pc100", pc_out, 32'h100);
    check("d_valid100", {31'd0, valid_out}, 32'd1);
    check("d_addr104", instr_address_out, 32'h104);
    idle(1'b1);
    check("d_addr108", instr_address_out, 32'h108);
    idle(1'b1);

    // Mispredict while the request waits two cycles: old request held.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 1'b0);
    check("d_drain_addr", instr_address_out, 32'h10C);
    idle(1'b0);
    check("d_drain_addr2", instr_address_out, 32'h10C);
    idle(1'b1);
    check("d_drain_novalid", {31'd0, valid_out}, 32'd0);
    check("d_addr400", instr_address_out, 32'h400);

    // Predicted-taken backward branch at 0x200.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0, 1'b1, 1'b0);
    idle(1'b1);
    check("d_beq_pred", {31'd0, branch_predicted_taken_out}, 32'd1);
    check("d_beq_pc", pc_out, 32'h200);
    check("d_addr1fc", instr_address_out, 32'h1FC);

    // Response arrives under a three-cycle stall.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    check("d_hold_noreq", {31'd0, instr_read_out}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    check("d_frozen_pc", pc_out, 32'h200);
    idle(1'b0);
    check("d_release_pc", pc_out, 32'h1FC);
    check("d_release_instr", instr_out, ADDI);
    check("d_release_addr", instr_address_out, 32'h200);

    // Access fault halts fetch until a trap redirect.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    check("d_fault_cause", {28'd0, exception_cause_out}, 32'd1);
    idle(1'b0);
    idle(1'b0);
    check("d_halt_noreq", {31'd0, instr_read_out}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h80, 1'b0, 1'b0);
    check("d_trap_addr", instr_address_out, 32'h80);

    // Misaligned trap target.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h82, 1'b1, 1'b0);
    check("d_mis_noreq", {31'd0, instr_read_out}, 32'd0);
    idle(1'b0);
    check("d_mis_pc", pc_out, 32'h82);
    check("d_mis_cause", {28'd0, exception_cause_out}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 1'b0);

    // Randomized run against the model.
    for (int n = 0; n < 4000; n++) begin
      bit          ce, st, fl, mi, tr, rd, ft;
      logic [31:0] bt, tt;
      ce = ($urandom_range(0, 9) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 15) == 0);
      mi = ($urandom_range(0, 19) == 0);
      tr = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 3) == 0);
      bt = {18'd0, 12'($urandom_range(0, 1023)), 2'b00};
      tt = {18'd0, 12'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 7) == 0) bt = bt + 32'd2;
      if ($urandom_range(0, 7) == 0) tt = tt + 32'd2;
      rd = model_req() && ($urandom_range(0, 9) < 6);
      ft = rd && ($urandom_range(0, 31) == 0);
      step(ce, st, fl, mi, bt, tr, tt, rd, ft);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
